// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order retire FIFO that replaces the writeback stage.
//   MEM results enter through mem_to_wb_valid / wb_allowin. The head entry retires at most
//   one per cycle unless retire_stall is set. On retire it writes the regfile, selects the
//   CSR needed for the regfile value or the redirect target, and raises the exception, ertn
//   or refetch flush. wb_pend_mask exposes every queued destination register for RAW checks.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   mem_to_wb_valid/wb_allowin  enqueue handshake; in_* carry the entry fields
//   retire_stall                hold the head this cycle
//   csr_re/csr_num/csr_rvalue   same-cycle CSR read port
//   rf_we/rf_waddr/rf_wdata     regfile write port
//   wb_ex/wb_ecode/wb_ex_pc     exception retire
//   ertn_flush/wb_refetch_flush other flush kinds; wb_flush_entry is the redirect target
//   wb_pend_mask                bit r = some queued entry writes register r (bit 0 never set)
// Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* retire trace ports.
module wb_retire_queue #(
    parameter int DEPTH   = 2,
    parameter int DATA_W  = 32,
    parameter int ECODE_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               mem_to_wb_valid,
    output logic               wb_allowin,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic               in_rf_we,
    input  logic [4:0]         in_rf_waddr,
    input  logic [DATA_W-1:0]  in_rf_wdata,
    input  logic               in_csr_re,
    input  logic [13:0]        in_csr_num,
    input  logic               in_ex,
    input  logic [ECODE_W-1:0] in_ecode,
    input  logic               in_ertn,
    input  logic               in_refetch,
    input  logic               retire_stall,
    input  logic [DATA_W-1:0]  csr_rvalue,
    output logic               csr_re,
    output logic [13:0]        csr_num,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               wb_ex,
    output logic [ECODE_W-1:0] wb_ecode,
    output logic [DATA_W-1:0]  wb_ex_pc,
    output logic               ertn_flush,
    output logic               wb_refetch_flush,
    output logic [DATA_W-1:0]  wb_flush_entry,
    output logic [31:0]        wb_pend_mask
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [DATA_W-1:0]  debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [DATA_W-1:0]  rf_wdata;
        logic               csr_re;
        logic [13:0]        csr_num;
        logic               ex;
        logic [ECODE_W-1:0] ecode;
        logic               ertn;
        logic               refetch;
    } entry_t;

    logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
    logic [PTR_W-1:0] tail_ptr_reg, tail_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    entry_t           entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    entry_t           in_entry;
    entry_t           head;
    logic             head_valid;
    logic             fire_in;
    logic             retire;
    logic             flush;

    assign in_entry = '{pc: in_pc, rf_we: in_rf_we, rf_waddr: in_rf_waddr, rf_wdata: in_rf_wdata,
                        csr_re: in_csr_re, csr_num: in_csr_num, ex: in_ex, ecode: in_ecode,
                        ertn: in_ertn, refetch: in_refetch};

    assign head       = entry_q[head_ptr_reg];
    assign head_valid = valid_q[head_ptr_reg];
    assign retire     = head_valid & ~retire_stall;
    // A full queue still accepts when the head leaves in the same cycle.
    assign wb_allowin = (count_reg < CNT_W'(DEPTH)) | retire;
    assign fire_in    = mem_to_wb_valid & wb_allowin;
    // Any flush kind implies retire, so wb_allowin stays high and MEM drains.
    assign flush      = retire & (head.ex | head.ertn | head.refetch);

    // Per-entry storage; an entry accepted during a flush is written but never marked valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            entry_t entry_reg;
            logic   valid_reg;
            logic   wr_hit;
            logic   rd_hit;

            assign wr_hit = fire_in & (tail_ptr_reg == PTR_W'(gi));
            assign rd_hit = retire & (head_ptr_reg == PTR_W'(gi));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    entry_reg <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        entry_reg <= in_entry;
                    end
                    if (flush) begin
                        valid_reg <= 1'b0;
                    end else if (wr_hit) begin
                        valid_reg <= 1'b1;
                    end else if (rd_hit) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign entry_q[gi] = entry_reg;
            assign valid_q[gi] = valid_reg;
        end
    endgenerate

    always_comb begin
        head_ptr_next = head_ptr_reg;
        tail_ptr_next = tail_ptr_reg;
        count_next    = count_reg;
        if (flush) begin
            head_ptr_next = '0;
            tail_ptr_next = '0;
            count_next    = '0;
        end else begin
            if (fire_in) begin
                tail_ptr_next = tail_ptr_reg + PTR_W'(1);
            end
            if (retire) begin
                head_ptr_next = head_ptr_reg + PTR_W'(1);
            end
            case ({fire_in, retire})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            head_ptr_reg <= head_ptr_next;
            tail_ptr_reg <= tail_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Head-derived outputs. The CSR port is driven whenever a head is present so the
    // read data is ready in the cycle the head retires.
    always_comb begin
        csr_re           = head_valid & (head.csr_re | head.ex | head.ertn);
        csr_num          = '0;
        if (head_valid) begin
            if (head.ex) begin
                csr_num = (head.ecode == ECODE_W'(6'h3f)) ? 14'h88 : 14'h0c;
            end else if (head.ertn) begin
                csr_num = 14'h06;
            end else begin
                csr_num = head.csr_num;
            end
        end
        rf_we            = retire & head.rf_we & ~head.ex;
        rf_waddr         = retire ? head.rf_waddr : 5'd0;
        rf_wdata         = '0;
        wb_ex            = retire & head.ex;
        wb_ecode         = (retire & head.ex) ? head.ecode : '0;
        wb_ex_pc         = retire ? head.pc : '0;
        ertn_flush       = retire & head.ertn & ~head.ex;
        wb_refetch_flush = retire & head.refetch & ~head.ex & ~head.ertn;
        wb_flush_entry   = '0;
        if (retire) begin
            rf_wdata       = head.csr_re ? csr_rvalue : head.rf_wdata;
            wb_flush_entry = (head.ex | head.ertn) ? csr_rvalue : head.pc + DATA_W'(4);
        end
    end

    always_comb begin
        wb_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && entry_q[i].rf_we) begin
                wb_pend_mask[entry_q[i].rf_waddr] = 1'b1;
            end
        end
        wb_pend_mask[0] = 1'b0;
    end

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = retire ? head.pc : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed self-checking bench for wb_retire_queue (DEPTH=2, DATA_W=32, ECODE_W=6).
module tb_wb_retire_queue;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_to_wb_valid = 1'b0;
    logic        wb_allowin;
    logic [31:0] in_pc = '0;
    logic        in_rf_we = 1'b0;
    logic [4:0]  in_rf_waddr = '0;
    logic [31:0] in_rf_wdata = '0;
    logic        in_csr_re = 1'b0;
    logic [13:0] in_csr_num = '0;
    logic        in_ex = 1'b0;
    logic [5:0]  in_ecode = '0;
    logic        in_ertn = 1'b0;
    logic        in_refetch = 1'b0;
    logic        retire_stall = 1'b0;
    logic [31:0] csr_rvalue = '0;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [31:0] wb_ex_pc;
    logic        ertn_flush;
    logic        wb_refetch_flush;
    logic [31:0] wb_flush_entry;
    logic [31:0] wb_pend_mask;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    wb_retire_queue #(.DEPTH(2), .DATA_W(32), .ECODE_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
        .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
        .in_csr_re(in_csr_re), .in_csr_num(in_csr_num), .in_ex(in_ex), .in_ecode(in_ecode),
        .in_ertn(in_ertn), .in_refetch(in_refetch), .retire_stall(retire_stall),
        .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_num(csr_num),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_ex_pc(wb_ex_pc),
        .ertn_flush(ertn_flush), .wb_refetch_flush(wb_refetch_flush),
        .wb_flush_entry(wb_flush_entry), .wb_pend_mask(wb_pend_mask)
`ifdef WB_DEBUG_TRACE_EN
        , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Drive one entry onto the MEM side (valid is set separately).
    task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic cre, input logic [13:0] cnum,
                         input logic ex, input logic [5:0] ec, input logic er, input logic rf);
        in_pc = pc; in_rf_we = we; in_rf_waddr = wa; in_rf_wdata = wd;
        in_csr_re = cre; in_csr_num = cnum; in_ex = ex; in_ecode = ec;
        in_ertn = er; in_refetch = rf;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cre;
        logic [13:0] cnum;
        logic        ex;
        logic [5:0]  ec;
        logic        er;
        logic        rf;
        logic [31:0] rval;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_ex;
        logic        e_ertn;
        logic        e_ref;
        logic        e_cre;
        logic [13:0] e_cnum;
        logic [31:0] e_fent;
    } vec_t;

    vec_t tab [7];

    initial begin
        //            name       pc            we wa  wd          cre cnum    ex ec     er rf rval
        //            e_we e_wdata  e_ex e_ertn e_ref e_cre e_cnum  e_fent
        tab[0] = '{"normal",  32'h1c000010, 1, 3, 32'h11, 0, 14'h05, 0, 6'h00, 0, 0, 32'h55,
                   1, 32'h11,        0, 0, 0, 0, 14'h05, 32'h1c000014};
        tab[1] = '{"csr_read", 32'h1c000020, 1, 4, 32'h22, 1, 14'h40, 0, 6'h00, 0, 0, 32'hdeadbeef,
                   1, 32'hdeadbeef,  0, 0, 0, 1, 14'h40, 32'h1c000024};
        tab[2] = '{"ex_3f",   32'h1c000030, 1, 5, 32'h33, 0, 14'h00, 1, 6'h3f, 0, 0, 32'h1c008000,
                   0, 32'h33,        1, 0, 0, 1, 14'h88, 32'h1c008000};
        tab[3] = '{"ex_ertn", 32'h1c000040, 0, 0, 32'h00, 0, 14'h00, 1, 6'h08, 1, 0, 32'h1c009000,
                   0, 32'h00,        1, 0, 0, 1, 14'h0c, 32'h1c009000};
        tab[4] = '{"ertn",    32'h1c000050, 0, 0, 32'h00, 0, 14'h00, 0, 6'h00, 1, 0, 32'h1c00a000,
                   0, 32'h00,        0, 1, 0, 1, 14'h06, 32'h1c00a000};
        tab[5] = '{"refetch_wrap", 32'hfffffffc, 1, 6, 32'h66, 0, 14'h18, 0, 6'h00, 0, 1, 32'h77,
                   1, 32'h66,        0, 0, 1, 0, 14'h18, 32'h00000000};
        tab[6] = '{"ertn_refetch", 32'h1c000060, 0, 0, 32'h00, 0, 14'h00, 0, 6'h00, 1, 1, 32'h1c00b000,
                   0, 32'h00,        0, 1, 0, 1, 14'h06, 32'h1c00b000};

        // Reset state while resetn is low.
        #2;
        chk("rst_allowin", 32'(wb_allowin), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_csr_re", 32'(csr_re), 32'd0);
        chk("rst_csr_num", 32'(csr_num), 32'd0);
        chk("rst_pend", wb_pend_mask, 32'd0);
        chk("rst_fent", wb_flush_entry, 32'd0);
        tick();
        resetn = 1'b1;

        // Table: each entry goes in alone, is checked as head, then retires.
        for (int i = 0; i < 7; i++) begin
            drive(tab[i].pc, tab[i].we, tab[i].wa, tab[i].wd, tab[i].cre, tab[i].cnum,
                  tab[i].ex, tab[i].ec, tab[i].er, tab[i].rf);
            mem_to_wb_valid = 1'b1;
            #1;
            chk({tab[i].name, "_allowin"}, 32'(wb_allowin), 32'd1);
            tick();
            mem_to_wb_valid = 1'b0;
            csr_rvalue = tab[i].rval;
            #1;
            chk({tab[i].name, "_rf_we"}, 32'(rf_we), 32'(tab[i].e_we));
            chk({tab[i].name, "_rf_waddr"}, 32'(rf_waddr), 32'(tab[i].wa));
            chk({tab[i].name, "_rf_wdata"}, rf_wdata, tab[i].e_wdata);
            chk({tab[i].name, "_wb_ex"}, 32'(wb_ex), 32'(tab[i].e_ex));
            chk({tab[i].name, "_ecode"}, 32'(wb_ecode), tab[i].e_ex ? 32'(tab[i].ec) : 32'd0);
            chk({tab[i].name, "_ertn"}, 32'(ertn_flush), 32'(tab[i].e_ertn));
            chk({tab[i].name, "_refetch"}, 32'(wb_refetch_flush), 32'(tab[i].e_ref));
            chk({tab[i].name, "_csr_re"}, 32'(csr_re), 32'(tab[i].e_cre));
            chk({tab[i].name, "_csr_num"}, 32'(csr_num), 32'(tab[i].e_cnum));
            chk({tab[i].name, "_fent"}, wb_flush_entry, tab[i].e_fent);
            chk({tab[i].name, "_ex_pc"}, wb_ex_pc, tab[i].pc);
`ifdef WB_DEBUG_TRACE_EN
            chk({tab[i].name, "_dbg_we"}, 32'(debug_wb_rf_we), tab[i].e_we ? 32'hf : 32'h0);
`endif
            tick();
            chk({tab[i].name, "_empty_pend"}, wb_pend_mask, 32'd0);
            chk({tab[i].name, "_empty_csr_re"}, 32'(csr_re), 32'd0);
            $display("vector %0d %s pc=0x%08h applied", i, tab[i].name, tab[i].pc);
        end

        // Back-to-back flow: four entries, one retire per cycle, order preserved.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                drive(32'h1c000000 + 32'(4 * (c + 1)), 1, 5'(c + 1), 32'(c + 1), 0, 0, 0, 0, 0, 0);
                mem_to_wb_valid = 1'b1;
            end else begin
                mem_to_wb_valid = 1'b0;
            end
            #1;
            chk($sformatf("b2b_allowin_%0d", c), 32'(wb_allowin), 32'd1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("b2b_rf_we_%0d", c), 32'(rf_we), 32'd1);
                chk($sformatf("b2b_waddr_%0d", c), 32'(rf_waddr), 32'(c));
                chk($sformatf("b2b_wdata_%0d", c), rf_wdata, 32'(c));
                chk($sformatf("b2b_pc_%0d", c), wb_ex_pc, 32'h1c000000 + 32'(4 * c));
            end else begin
                chk($sformatf("b2b_idle_%0d", c), 32'(rf_we), 32'd0);
            end
            $display("b2b cycle %0d rf_we=%0d waddr=%0d", c, rf_we, rf_waddr);
            tick();
        end

        // Full queue with the head stalled, then enqueue and retire together.
        retire_stall = 1'b1;
        drive(32'h1c001000, 1, 5, 32'h5, 0, 0, 0, 0, 0, 0);
        mem_to_wb_valid = 1'b1;
        #1;
        chk("full_allowin0", 32'(wb_allowin), 32'd1);
        tick();
        drive(32'h1c001004, 1, 6, 32'h6, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_allowin1", 32'(wb_allowin), 32'd1);
        chk("full_stall_rf_we", 32'(rf_we), 32'd0);
        tick();
        drive(32'h1c001008, 1, 7, 32'h7, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_allowin2", 32'(wb_allowin), 32'd0);
        chk("full_pend", wb_pend_mask, 32'h00000060);
        tick();
        chk("full_held_allowin", 32'(wb_allowin), 32'd0);
        retire_stall = 1'b0;
        #1;
        chk("full_release_allowin", 32'(wb_allowin), 32'd1);
        chk("full_release_waddr", 32'(rf_waddr), 32'd5);
        tick();
        mem_to_wb_valid = 1'b0;
        #1;
        chk("full_head_b", 32'(rf_waddr), 32'd6);
        chk("full_pend_bc", wb_pend_mask, 32'h000000c0);
        tick();
        chk("full_head_c", 32'(rf_waddr), 32'd7);
        chk("full_pend_c", wb_pend_mask, 32'h00000080);
        tick();
        chk("full_drained_pend", wb_pend_mask, 32'd0);
        chk("full_drained_rf_we", 32'(rf_we), 32'd0);
        $display("full sequence done");

        // Exception head flushes; the entry offered in the same cycle is dropped.
        drive(32'h1c002000, 1, 8, 32'h8, 0, 0, 1, 6'h3f, 0, 0);
        mem_to_wb_valid = 1'b1;
        tick();
        drive(32'h1c002004, 1, 9, 32'h9, 0, 0, 0, 0, 0, 0);
        csr_rvalue = 32'h1c008000;
        #1;
        chk("exdrop_allowin", 32'(wb_allowin), 32'd1);
        chk("exdrop_wb_ex", 32'(wb_ex), 32'd1);
        chk("exdrop_csr_num", 32'(csr_num), 32'h88);
        chk("exdrop_fent", wb_flush_entry, 32'h1c008000);
        chk("exdrop_rf_we", 32'(rf_we), 32'd0);
        tick();
        mem_to_wb_valid = 1'b0;
        #1;
        chk("exdrop_pend", wb_pend_mask, 32'd0);
        chk("exdrop_rf_we_after", 32'(rf_we), 32'd0);
        chk("exdrop_csr_re_after", 32'(csr_re), 32'd0);
        $display("exception drop sequence done");

        // Asynchronous reset with two entries queued behind a stalled head.
        retire_stall = 1'b1;
        drive(32'h1c003000, 1, 10, 32'ha, 1, 14'h40, 0, 0, 0, 0);
        mem_to_wb_valid = 1'b1;
        tick();
        drive(32'h1c003004, 1, 11, 32'hb, 0, 0, 0, 0, 0, 0);
        tick();
        mem_to_wb_valid = 1'b0;
        #1;
        chk("areset_pre_pend", wb_pend_mask, 32'h00000c00);
        chk("areset_pre_csr_re", 32'(csr_re), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("areset_allowin", 32'(wb_allowin), 32'd1);
        chk("areset_pend", wb_pend_mask, 32'd0);
        chk("areset_csr_re", 32'(csr_re), 32'd0);
        chk("areset_csr_num", 32'(csr_num), 32'd0);
        tick();
        resetn = 1'b1;
        retire_stall = 1'b0;
        tick();
        chk("areset_after_pend", wb_pend_mask, 32'd0);
        $display("async reset sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
